fwht_butterfly_stage: RTL



---
 rtl/fwht_pkg.sv | 14 +
 rtl/fwht_delay_line.sv | 74 +++++++
 rtl/fwht_delay_line_chk.sv | 15 +
 rtl/fwht_butterfly_stage.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fwht_pkg.sv
// Shared definitions for the streaming Fast Walsh-Hadamard Transform pipeline.
// Each butterfly stage widens its samples by one bit.
package fwht_pkg;

    typedef enum logic {
        PH_FILL    = 1'b0,
        PH_COMPUTE = 1'b1
    } phase_e;

    function automatic int stage_out_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/fwht_delay_line.sv
// Depth-2^M_WIDTH FIFO holding first-half samples and pending differences.
// Read data is registered; illegal accesses are dropped.
module fwht_delay_line
    import fwht_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int M_WIDTH = 2,
    localparam int DW     = stage_out_width(WIDTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int DEPTH = 1 << M_WIDTH;

    logic [DW-1:0]    mem [DEPTH];
    logic [M_WIDTH:0] wr_ptr;
    logic [M_WIDTH:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Status flags from the extra wrap bit of each pointer.
    always_comb begin
        o_empty = (wr_ptr == rd_ptr);
        o_full  = (wr_ptr[M_WIDTH] != rd_ptr[M_WIDTH]) &&
                  (wr_ptr[M_WIDTH-1:0] == rd_ptr[M_WIDTH-1:0]);
        wr_ok   = i_wr_en && !o_full;
        rd_ok   = i_rd_en && !o_empty;
    end

    // Pointer advance.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end else begin
                wr_ptr <= wr_ptr;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end else begin
                rd_ptr <= rd_ptr;
            end
        end
    end

    // Storage array.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_ptr[M_WIDTH-1:0]] <= i_wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rd_data <= '0;
        end else if (rd_ok) begin
            o_rd_data <= mem[rd_ptr[M_WIDTH-1:0]];
        end else begin
            o_rd_data <= o_rd_data;
        end
    end

endmodule

// File: rtl/fwht_delay_line_chk.sv
// Checker for delay-line access legality.
// Overflow and underflow can only come from a broken stage sequencer.
module fwht_delay_line_chk (
    input logic i_clk,
    input logic i_reset,
    input logic i_wr_en,
    input logic i_rd_en,
    input logic i_full,
    input logic i_empty
);

    wr_not_full: assert property (@(posedge i_clk) disable iff (i_reset) !(i_wr_en && i_full));
    rd_not_empty: assert property (@(posedge i_clk) disable iff (i_reset) !(i_rd_en && i_empty));

endmodule

// File: rtl/fwht_butterfly_stage.sv
// Radix-2 single-delay-feedback Walsh-Hadamard stage: per block of 2D samples
// it emits D sums, then the D differences during the following FILL phase.
module fwht_butterfly_stage
    import fwht_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int M_WIDTH = 2,
    localparam int OW     = stage_out_width(WIDTH)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    input  logic signed [WIDTH-1:0] i_data,
    output logic                    o_valid,
    output logic signed [OW-1:0]    o_data,
    output logic                    o_sop
);

    localparam logic [M_WIDTH-1:0] CNT_LAST = {M_WIDTH{1'b1}};
    localparam logic [M_WIDTH-1:0] CNT_ZERO = {M_WIDTH{1'b0}};

    logic [M_WIDTH-1:0]   cnt;
    logic [M_WIDTH-1:0]   cnt_next;
    phase_e               phase;
    phase_e               phase_next;
    logic                 pending;
    logic                 pending_next;

    logic                 s1_valid;
    logic                 s1_emit;
    logic                 s1_sop;
    phase_e               s1_phase;
    logic signed [OW-1:0] s1_x;

    logic                 emit;
    logic signed [OW-1:0] x_ext;
    logic                 rd_en;
    logic                 wr_en;
    logic signed [OW-1:0] wr_data;
    logic signed [OW-1:0] rd_data;
    logic signed [OW-1:0] stage_out;
    logic                 dl_full;
    logic                 dl_empty;

    // Sequencer state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt     <= '0;
            phase   <= PH_FILL;
            pending <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            phase   <= phase_next;
            pending <= pending_next;
        end
    end

    // Sequencer next state; pending latches once the first COMPUTE phase ends.
    always_comb begin
        cnt_next     = cnt;
        phase_next   = phase;
        pending_next = pending;
        if (i_valid) begin
            cnt_next = cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                phase_next = (phase == PH_FILL) ? PH_COMPUTE : PH_FILL;
                if (phase == PH_COMPUTE) begin
                    pending_next = 1'b1;
                end else begin
                    pending_next = pending;
                end
            end else begin
                phase_next = phase;
            end
        end else begin
            cnt_next = cnt;
        end
    end

    // Sequencer outputs and the stage-2 butterfly; all delay-line writes happen
    // one cycle after acceptance so FILL and difference writes never collide.
    always_comb begin
        x_ext = {i_data[WIDTH-1], i_data};
        emit  = (phase == PH_COMPUTE) || pending;
        rd_en = i_valid && emit && !i_reset;
        wr_en = s1_valid && !i_reset;
        if (s1_phase == PH_COMPUTE) begin
            wr_data   = rd_data - s1_x;
            stage_out = rd_data + s1_x;
        end else begin
            wr_data   = s1_x;
            stage_out = rd_data;
        end
    end

    // Stage 1: capture the accepted sample alongside its phase context.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_emit  <= 1'b0;
            s1_sop   <= 1'b0;
            s1_phase <= PH_FILL;
            s1_x     <= '0;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_emit  <= emit;
                s1_sop   <= (phase == PH_COMPUTE) && (cnt == CNT_ZERO);
                s1_phase <= phase;
                s1_x     <= x_ext;
            end else begin
                s1_emit  <= s1_emit;
                s1_sop   <= s1_sop;
                s1_phase <= s1_phase;
                s1_x     <= s1_x;
            end
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_sop   <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= s1_valid && s1_emit;
            o_sop   <= s1_valid && s1_emit && s1_sop;
            if (s1_valid && s1_emit) begin
                o_data <= stage_out;
            end else begin
                o_data <= o_data;
            end
        end
    end

    fwht_delay_line #(
        .WIDTH   (WIDTH),
        .M_WIDTH (M_WIDTH)
    ) u_delay_line (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .i_rd_en   (rd_en),
        .o_rd_data (rd_data),
        .o_full    (dl_full),
        .o_empty   (dl_empty)
    );

    fwht_delay_line_chk u_delay_line_chk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr_en (wr_en),
        .i_rd_en (rd_en),
        .i_full  (dl_full),
        .i_empty (dl_empty)
    );

endmodule
